imem_loader: RTL
================

# imem_loader

Parametrised instruction-memory loader that turns beats presented on a bidirectional pad bank into complete {address, data} imem write transactions. Compared with the fixed 8-bit, 50-bit-word loader it replaces, it adds frame counting, an explicit write strobe, a mid-frame timeout, an abort on mode exit, sticky error flags and an optional per-frame checksum. It sits between the pad ring's MEMLOAD-mode inputs and the core's imem write port, entirely in the clk_int domain.

## Interface
- IN_WIDTH, 8: beat width in bits (pad bank width).
- ADDR_WIDTH, 10: imem address width.
- DATA_WIDTH, 40: imem word width.
- SYNC_STAGES, 2: synchroniser depth on all asynchronous inputs; minimum 2.
- TIMEOUT_CYCLES, 1024: maximum clk_int cycles allowed between beats inside a frame.

Ports:
- clk_int  in  1  core clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- mode_memload  in  1  asynchronous; high while the chip is in MEMLOAD mode.
- load_clk  in  1  asynchronous beat strobe; the rising edge marks one beat.
- load_data  in  IN_WIDTH  asynchronous beat value.
- imem_write_adr  out  ADDR_WIDTH  address of the last committed frame.
- imem_in  out  DATA_WIDTH  data of the last committed frame.
- imem_write_en  out  1  one-cycle write strobe.
- busy  out  1  high while a frame is partially received.
- err  out  3  sticky error flags: [0] checksum, [1] timeout, [2] abort.
- word_count  out  ADDR_WIDTH+1  count of committed frames; saturates at all-ones.

## Operation
- BEATS = ceil((ADDR_WIDTH+DATA_WIDTH)/IN_WIDTH); the default is 7.
- Frames are sent MSB-first. The BEATS×IN_WIDTH shift register holds the frame. The low DATA_WIDTH bits are data, the next ADDR_WIDTH bits are address, and any surplus top bits are ignored.
- mode_memload, load_clk and load_data each pass through SYNC_STAGES flops. A beat is a rising edge on the synchronised load_clk (compared against a one-flop delayed copy). The beat value is the synchronised load_data in that same cycle.
- State machine:
  - IDLE: entered when synchronised mode_memload is low; beats are ignored. A rising edge on mode_memload clears err and moves to COLLECT.
  - COLLECT: each beat shifts in and increments beat_cnt. When beat_cnt reaches the last beat of the frame, go to COMMIT.
  - COMMIT: lasts one cycle. imem_write_adr and imem_in update from the frame, imem_write_en=1 and word_count increments. beat_cnt clears and the state returns to COLLECT.
- Timeout: in COLLECT with beat_cnt>0, a counter runs and clears on every beat. When it reaches TIMEOUT_CYCLES, the partial frame is discarded, err[1] is set and beat_cnt returns to 0.
- Abort: mode_memload falling in COLLECT with beat_cnt>0 discards the frame and sets err[2]. In any state, mode_memload falling moves to IDLE.
- busy = (state==COLLECT && beat_cnt>0).

## Timing
- Reset values: all outputs 0, state IDLE, shift register 0.
- Latency: a pin edge on load_clk is detected SYNC_STAGES+1 cycles later. The commit strobe follows the final beat's detection cycle by 1 cycle.
- imem_write_adr and imem_in stay stable from COMMIT until the next COMMIT.
- load_data must be stable from SYNC_STAGES+1 cycles before to SYNC_STAGES+1 cycles after each load_clk rising edge.
- Beat detected in the COMMIT cycle: it is accepted as beat 0 of the next frame.
- Beat and timeout expiry in the same cycle: the beat wins and the counter clears.
- mode_memload falling in the same cycle as the final beat: the beat is ignored, the frame is aborted and err[2] is set.
- word_count at all-ones: writes still occur and the count holds.
- Asynchronous reset mid-frame: the partial frame is lost and no write strobe is produced.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - Each frame carries one extra trailing beat, so the frame is BEATS+1 beats.
  - COMMIT checks that the sum of all BEATS+1 beats, mod 2^IN_WIDTH, is 0.
  - On mismatch there is no imem_write_en, no word_count increment and no output update, and err[0] is set.
- Undefined: the frame is BEATS beats, no check is made, and err[0] is tied to 0.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (IDLE, COLLECT, COMMIT);
  - the beats-per-frame function;
  - the err bit index constants ERR_CSUM, ERR_TIMEOUT, ERR_ABORT.
- Sub-module pad_sync: a parametrised N-stage, W-bit synchroniser, instantiated once for {mode_memload, load_clk, load_data}.

## Test plan
- Reset while frame beats are arriving: all outputs read 0, and imem_write_en stays 0 after release.
- Checksum undefined, beats 0x03,0xFF,0x12,0x34,0x56,0x78,0x9A -> one imem_write_en pulse with adr=0x3FF, data=0x123456789A, word_count=1.
- Checksum defined, same 7 beats then 0x50 -> write as above. Same 7 beats then 0x51 -> no write, err=3'b001.
- 3 beats, then no beat for 1024 cycles -> err[1]=1 and busy=0. A following full 7-beat frame then commits correctly.
- mode_memload dropped after 4 beats -> err[2]=1 and state IDLE. mode_memload raised again -> err=0.
- Two back-to-back frames with the first beat of frame 2 landing in the COMMIT cycle -> two writes, with the second frame's address and data correct.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and helpers for the imem loader. Holds the
//               loader state encoding, the beats-per-frame calculation and
//               the bit positions of the sticky error flags.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int ERR_CSUM    = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_ABORT   = 2;

  // Number of pad beats needed to carry one {address, data} word.
  function automatic int beats_per_frame(input int addr_w, input int data_w, input int in_w);
    return (addr_w + data_w + in_w - 1) / in_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_pad_sync.sv
`default_nettype none
// ============================================================================
// Module      : pad_sync
// Description : STAGES-deep, WIDTH-bit flop synchroniser for pad inputs that
//               are asynchronous to clk.
// Ports       : clk   - destination clock
//               reset - asynchronous active-high reset
//               din   - asynchronous input bus
//               dout  - synchronised output bus
// Revision    : 1.0 - initial release
// ============================================================================
module pad_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_pipe [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= din;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign dout = r_pipe[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Collects MSB-first beats from the MEMLOAD pad bank into
//               {address, data} frames and issues one-cycle imem writes.
//               Counts committed frames, flags timeout / abort errors and,
//               when IMEM_LOADER_CHECKSUM_EN is defined, checks a trailing
//               per-frame checksum beat (sum of all beats == 0).
// Ports       : clk_int        - core clock
//               reset          - asynchronous active-high reset
//               mode_memload   - async, high while in MEMLOAD mode
//               load_clk       - async beat strobe (rising edge = beat)
//               load_data      - async beat value
//               imem_write_adr - address of last committed frame
//               imem_in        - data of last committed frame
//               imem_write_en  - one-cycle write strobe
//               busy           - frame partially received
//               err            - sticky flags [0] csum [1] timeout [2] abort
//               word_count     - committed frames, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IN_WIDTH       = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 40,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_int,
  input  logic                  reset,
  input  logic                  mode_memload,
  input  logic                  load_clk,
  input  logic [IN_WIDTH-1:0]   load_data,
  output logic [ADDR_WIDTH-1:0] imem_write_adr,
  output logic [DATA_WIDTH-1:0] imem_in,
  output logic                  imem_write_en,
  output logic                  busy,
  output logic [2:0]            err,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int BEATS = beats_per_frame(ADDR_WIDTH, DATA_WIDTH, IN_WIDTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int FRAME_BEATS = BEATS + 1;
`else
  localparam int FRAME_BEATS = BEATS;
`endif
  // Only the meaningful address+data bits are kept; surplus top bits of the
  // frame simply fall off the end of the shift register.
  localparam int FRAME_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_BEATS + 1);
  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronised pad inputs
  logic [IN_WIDTH+1:0] w_sync;
  logic                w_mode;
  logic                w_lclk;
  logic [IN_WIDTH-1:0] w_beat_data;

  pad_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (IN_WIDTH + 2)
  ) u_pad_sync (
    .clk   (clk_int),
    .reset (reset),
    .din   ({mode_memload, load_clk, load_data}),
    .dout  (w_sync)
  );

  assign w_mode      = w_sync[IN_WIDTH+1];
  assign w_lclk      = w_sync[IN_WIDTH];
  assign w_beat_data = w_sync[IN_WIDTH-1:0];

  // State and datapath registers
  state_t                r_state;
  logic                  r_mode_q;
  logic                  r_lclk_q;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [TMR_W-1:0]      r_timer;
  logic [FRAME_W-1:0]    r_shift;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_we;
  logic [2:0]            r_err;
  logic [ADDR_WIDTH:0]   r_wc;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [TMR_W-1:0]      w_tmr_nxt;
  logic [FRAME_W-1:0]    w_shift_nxt;
  logic [ADDR_WIDTH-1:0] w_adr_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_we_nxt;
  logic [2:0]            w_err_nxt;
  logic [ADDR_WIDTH:0]   w_wc_nxt;

  logic                  w_beat;
  logic                  w_mode_rise;
  logic                  w_mode_fall;
  logic                  w_last_beat;
  logic [FRAME_W-1:0]    w_frame_shift;
  logic [FRAME_W-1:0]    w_commit_frame;
  logic                  w_csum_ok;

  assign w_beat        = w_lclk & ~r_lclk_q;
  assign w_mode_rise   = w_mode & ~r_mode_q;
  assign w_mode_fall   = ~w_mode & r_mode_q;
  assign w_last_beat   = (r_beat_cnt == CNT_W'(FRAME_BEATS - 1));
  assign w_frame_shift = (r_shift << IN_WIDTH) | FRAME_W'(w_beat_data);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [IN_WIDTH-1:0] r_sum;
  logic [IN_WIDTH-1:0] w_sum_nxt;
  logic [IN_WIDTH-1:0] w_sum_add;

  assign w_sum_add      = r_sum + w_beat_data;
  // The final beat is the checksum itself; the frame is already complete.
  assign w_commit_frame = r_shift;
  assign w_csum_ok      = (w_sum_add == '0);
`else
  assign w_commit_frame = w_frame_shift;
  assign w_csum_ok      = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    w_tmr_nxt   = r_timer;
    w_shift_nxt = r_shift;
    w_adr_nxt   = r_adr;
    w_data_nxt  = r_data;
    w_we_nxt    = 1'b0;
    w_err_nxt   = r_err;
    w_wc_nxt    = r_wc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_sum_nxt   = r_sum;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_tmr_nxt = '0;
        if (w_mode_rise) begin
          w_err_nxt   = '0;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT, COMMIT: begin
        // Mode exit takes priority over a coincident beat.
        if (w_mode_fall) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_tmr_nxt   = '0;
          if (r_beat_cnt != '0) w_err_nxt[ERR_ABORT] = 1'b1;
        end else if (w_beat) begin
          // In COMMIT beat_cnt is already 0, so the beat starts a new frame.
          w_tmr_nxt = '0;
          if (w_last_beat) begin
            w_state_nxt = COMMIT;
            w_cnt_nxt   = '0;
            if (w_csum_ok) begin
              // Registered here so address, data and strobe appear together
              // during the COMMIT cycle.
              w_adr_nxt  = w_commit_frame[DATA_WIDTH +: ADDR_WIDTH];
              w_data_nxt = w_commit_frame[DATA_WIDTH-1:0];
              w_we_nxt   = 1'b1;
              if (r_wc != '1) w_wc_nxt = r_wc + (ADDR_WIDTH+1)'(1);
            end else begin
              w_err_nxt[ERR_CSUM] = 1'b1;
            end
          end else begin
            w_state_nxt = COLLECT;
            w_cnt_nxt   = r_beat_cnt + CNT_W'(1);
            w_shift_nxt = w_frame_shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_sum_nxt   = (r_beat_cnt == '0) ? w_beat_data : w_sum_add;
`endif
          end
        end else begin
          w_state_nxt = COLLECT;
          if (r_state == COLLECT && r_beat_cnt != '0) begin
            if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
              w_err_nxt[ERR_TIMEOUT] = 1'b1;
              w_cnt_nxt              = '0;
              w_tmr_nxt              = '0;
            end else begin
              w_tmr_nxt = r_timer + TMR_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mode_q   <= 1'b0;
      r_lclk_q   <= 1'b0;
      r_beat_cnt <= '0;
      r_timer    <= '0;
      r_shift    <= '0;
      r_adr      <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_err      <= '0;
      r_wc       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_mode_q   <= w_mode;
      r_lclk_q   <= w_lclk;
      r_beat_cnt <= w_cnt_nxt;
      r_timer    <= w_tmr_nxt;
      r_shift    <= w_shift_nxt;
      r_adr      <= w_adr_nxt;
      r_data     <= w_data_nxt;
      r_we       <= w_we_nxt;
      r_err      <= w_err_nxt;
      r_wc       <= w_wc_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= w_sum_nxt;
`endif
    end
  end

  assign imem_write_adr = r_adr;
  assign imem_in        = r_data;
  assign imem_write_en  = r_we;
  assign err            = r_err;
  assign word_count     = r_wc;
  assign busy           = (r_state == COLLECT) && (r_beat_cnt != '0);

endmodule
`default_nettype wire
